// File: rtl/mem_dump_reader.sv
// Debug memory dump reader: walks data-memory words 0..DEPTH-1 and streams
// each word MSB byte first over a valid/ready byte interface.
module mem_dump_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_start,
    output logic [DATA_WIDTH-1:0] o_address,
    output logic                  o_memread,
    output logic                  o_memwrite,
    input  logic [DATA_WIDTH-1:0] i_dataread,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LATCH = 3'd2,
        SEND  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                  state_r, state_s;
    logic [IDX_W-1:0]        idx_r, idx_s;
    logic [CNT_W-1:0]        cnt_r, cnt_s;
    logic [DATA_WIDTH-1:0]   word_r, word_s, word_shift_s;
    logic [DATA_WIDTH-1:0]   addr_r, addr_s;
    logic                    memread_r, memread_s;
    logic [7:0]              tx_data_r, tx_data_s;
    logic                    tx_valid_r, tx_valid_s;
    logic                    busy_r, busy_s;
    logic                    done_r, done_s;

    // Next-state and next-output logic for the dump sequencer
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        cnt_s        = cnt_r;
        word_s       = word_r;
        addr_s       = addr_r;
        memread_s    = memread_r;
        tx_data_s    = tx_data_r;
        tx_valid_s   = tx_valid_r;
        busy_s       = busy_r;
        done_s       = 1'b0;
        word_shift_s = word_r << 4'd8;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    state_s   = READ;
                    idx_s     = '0;
                    addr_s    = '0;
                    memread_s = 1'b1;
                    busy_s    = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                state_s = LATCH;
            end
            LATCH: begin
                word_s     = i_dataread;
                memread_s  = 1'b0;
                tx_data_s  = i_dataread[DATA_WIDTH-1 -: 8];
                tx_valid_s = 1'b1;
                cnt_s      = '0;
                state_s    = SEND;
            end
            SEND: begin
                if (tx_valid_r && i_tx_ready) begin
                    if (cnt_r == CNT_LAST) begin
                        tx_valid_s = 1'b0;
                        if (idx_r != IDX_LAST) begin
                            idx_s     = idx_r + IDX_W'(1);
                            addr_s    = DATA_WIDTH'(idx_r + IDX_W'(1));
                            memread_s = 1'b1;
                            state_s   = READ;
                        end else begin
                            done_s  = 1'b1;
                            state_s = DONE;
                        end
                    end else begin
                        // Word register shifts so the next lower byte is always at the top
                        cnt_s     = cnt_r + CNT_W'(1);
                        word_s    = word_shift_s;
                        tx_data_s = word_shift_s[DATA_WIDTH-1 -: 8];
                    end
                end else begin
                    state_s = SEND;
                end
            end
            DONE: begin
                busy_s  = 1'b0;
                addr_s  = '0;
                state_s = IDLE;
            end
            default: begin
                state_s    = IDLE;
                memread_s  = 1'b0;
                tx_valid_s = 1'b0;
                busy_s     = 1'b0;
                addr_s     = '0;
            end
        endcase
    end

    // State and registered-output update
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r    <= IDLE;
            idx_r      <= '0;
            cnt_r      <= '0;
            word_r     <= '0;
            addr_r     <= '0;
            memread_r  <= 1'b0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            cnt_r      <= cnt_s;
            word_r     <= word_s;
            addr_r     <= addr_s;
            memread_r  <= memread_s;
            tx_data_r  <= tx_data_s;
            tx_valid_r <= tx_valid_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign o_address  = addr_r;
    assign o_memread  = memread_r;
    assign o_memwrite = 1'b0;
    assign o_tx_data  = tx_data_r;
    assign o_tx_valid = tx_valid_r;
    assign o_busy     = busy_r;
    assign o_done     = done_r;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed bench for mem_dump_reader: cycle table for the first words, then
// full dumps under backpressure, busy restart attempts and mid-dump reset.
module tb_mem_dump_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] address;
    logic        memread, memwrite;
    logic [31:0] dataread;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready, busy, done;
    logic        rnd_mode;
    logic [31:0] rnd_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign dataread = rnd_mode ? rnd_data : (32'hA0B0C000 + address);

    mem_dump_reader #(.DATA_WIDTH(32), .DEPTH(32)) dut (
        .i_clock    (clk),
        .i_reset_n  (rst_n),
        .i_start    (start),
        .o_address  (address),
        .o_memread  (memread),
        .o_memwrite (memwrite),
        .i_dataread (dataread),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_busy     (busy),
        .o_done     (done)
    );

    typedef struct {
        logic        ready;
        logic [31:0] addr;
        logic        mr;
        logic        v;
        logic [7:0]  d;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t tbl [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        logic [31:0] w;
        w = 32'hA0B0C000 + 32'(i / 4);
        return w[31 - 8 * (i % 4) -: 8];
    endfunction

    function automatic logic all_zero();
        return (address == 32'd0) && !memread && !memwrite && (tx_data == 8'h00)
            && !tx_valid && !busy && !done;
    endfunction

    // Full dump with ready held high pct% of the time; optional start poke at byte poke_at
    task automatic do_dump(input string tag, input int pct, input int poke_at,
                           input int exp_done, input logic b2b);
        logic [7:0] bytes [$];
        int cyc, hold_err, mw_err, mr_err, busy_err, byte_err, done_cyc;
        logic done_seen, poked, xfer, hold;
        logic [7:0] pdata;
        hold_err = 0; mw_err = 0; mr_err = 0; busy_err = 0; byte_err = 0;
        done_seen = 1'b0; poked = 1'b0; done_cyc = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        chk({tag, " start accepted"}, {busy, memread, address}, {1'b1, 1'b1, 32'd0});
        while (!done_seen && cyc < 5000) begin
            tx_ready = ($urandom_range(99) < pct);
            if (!poked && poke_at >= 0 && bytes.size() == poke_at) begin
                start = 1'b1;
                poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            xfer  = tx_valid && tx_ready;
            hold  = tx_valid && !tx_ready;
            pdata = tx_data;
            tick();
            cyc++;
            if (xfer) bytes.push_back(pdata);
            if (hold && (!tx_valid || tx_data != pdata)) hold_err++;
            if (memwrite) mw_err++;
            if (memread && ((bytes.size() % 4) != 0 || address != 32'(bytes.size() / 4))) mr_err++;
            if (!busy) busy_err++;
            if (done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
        end
        start = 1'b0;
        chk({tag, " done seen"}, done_seen, 1'b1);
        chk({tag, " byte count"}, bytes.size(), 128);
        for (int i = 0; i < bytes.size() && i < 128; i++)
            if (bytes[i] != exp_byte(i)) byte_err++;
        chk({tag, " byte errors"}, byte_err, 0);
        chk({tag, " hold errors"}, hold_err, 0);
        chk({tag, " memwrite"}, mw_err, 0);
        chk({tag, " memread addr"}, mr_err, 0);
        chk({tag, " busy gaps"}, busy_err, 0);
        if (exp_done >= 0) chk({tag, " done cycle"}, done_cyc, exp_done);
        // Start during the DONE cycle must be ignored
        start    = b2b;
        tx_ready = 1'b0;
        tick();
        chk({tag, " after done"}, {done, busy, memread, address}, 35'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; tx_ready = 1'b0;
        rnd_mode = 1'b1; rnd_data = 32'd0;

        // Reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            start    = 1'($urandom_range(1));
            tx_ready = 1'($urandom_range(1));
            rnd_data = $urandom;
            tick();
            chk("reset outputs", all_zero(), 1'b1);
        end
        start = 1'b0; tx_ready = 1'b0; rnd_mode = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("idle after reset", all_zero(), 1'b1);

        // Cycle-exact trace through word 0 and into word 1
        tbl[0]  = '{1'b1, 32'd0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 32'd0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 32'd0, 1'b0, 1'b1, 8'hA0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 32'd0, 1'b0, 1'b1, 8'hA0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 32'd0, 1'b0, 1'b1, 8'hB0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 32'd0, 1'b0, 1'b1, 8'hC0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 32'd0, 1'b0, 1'b1, 8'hC0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 32'd0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 32'd1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 32'd1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 32'd1, 1'b0, 1'b1, 8'hA0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 32'd1, 1'b0, 1'b1, 8'hB0, 1'b1, 1'b0};
        for (int i = 0; i < 12; i++) begin
            tx_ready = tbl[i].ready;
            start    = (i == 0);
            tick();
            start = 1'b0;
            chk($sformatf("table row %0d", i),
                {address, memread, tx_valid, (tx_valid ? tx_data : 8'h00), busy, done, memwrite},
                {tbl[i].addr, tbl[i].mr, tbl[i].v, tbl[i].d, tbl[i].busy, tbl[i].done, 1'b0});
        end
        #2 rst_n = 1'b0;
        #1 chk("abort reset", all_zero(), 1'b1);
        tick();
        rst_n = 1'b1;
        tick();

        do_dump("full", 100, -1, 193, 1'b1);
        do_dump("back2back", 100, -1, 193, 1'b0);
        do_dump("backpressure", 30, -1, -1, 1'b0);
        do_dump("start busy", 100, 10, 193, 1'b0);

        // Reset mid-dump while word 5 byte 2 is on the bus
        begin
            int n, cyc;
            logic xfer;
            n = 0; cyc = 0;
            tx_ready = 1'b1;
            start = 1'b1;
            tick();
            start = 1'b0;
            while (n < 22 && cyc < 500) begin
                xfer = tx_valid && tx_ready;
                tick();
                cyc++;
                if (xfer) n++;
            end
            chk("mid word", {address, tx_valid, tx_data}, {32'd5, 1'b1, 8'hC0});
            #2 rst_n = 1'b0;
            #1 chk("mid async reset", all_zero(), 1'b1);
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("mid no done", all_zero(), 1'b1);
            end
            rst_n = 1'b1;
            tick();
        end
        do_dump("after abort", 100, -1, 193, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_dump_reader.md
Name: mem_dump_reader

Overview:
- Debug-side reader for the MEM-stage data memory: on a start pulse, walks every data-memory word in order, reads it over the memory read port, and streams it out byte by byte over a valid/ready byte interface toward the debug UART transmitter.
- Sits between the data memory read port (via the debug mux, while the pipeline is halted) and the UART TX.
- Read-only master: never asserts a memory write.

Parameters:
- DATA_WIDTH, 32, memory word and address width; must be a multiple of 8.
- DEPTH, 32, number of words dumped; addresses 0..DEPTH-1 are word indices.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  one-cycle request to begin a full dump.
- o_address  out  DATA_WIDTH  word index driven to memory address port.
- o_memread  out  1  memory read enable.
- o_memwrite  out  1  memory write enable; constant 0.
- i_dataread  in  DATA_WIDTH  memory read data, valid combinationally while o_memread=1.
- o_tx_data  out  8  byte to transmitter.
- o_tx_valid  out  1  byte valid.
- i_tx_ready  in  1  transmitter accepts byte.
- o_busy  out  1  dump in progress.
- o_done  out  1  one-cycle pulse after last byte accepted.

Behaviour:
- Reset (async, i_reset_n=0): state IDLE; o_address=0, o_memread=0, o_memwrite=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0; word index and byte counter cleared. Asserting reset mid-dump aborts immediately; no done pulse; next dump restarts at address 0.
- All outputs are registered except o_memwrite (tied 0).
- FSM states: IDLE, READ, LATCH, SEND, DONE.
- IDLE: i_start=1 -> READ; o_address<=0, o_memread<=1, o_busy<=1. i_start ignored in every other state.
- READ: one cycle with address stable and o_memread=1 so read data settles -> LATCH.
- LATCH: capture i_dataread into word register; o_memread<=0; load first byte (bits [DATA_WIDTH-1:DATA_WIDTH-8], MSB first); o_tx_valid<=1; byte counter=0 -> SEND.
- SEND: a byte transfers on a cycle with o_tx_valid=1 and i_tx_ready=1. While o_tx_valid=1 and i_tx_ready=0, o_tx_data holds stable.
  - On transfer of a non-last byte: load the next lower byte on the following edge, keeping o_tx_valid=1. This allows back-to-back bytes, one per cycle, when ready is held high.
  - On transfer of the last byte (counter=DATA_WIDTH/8-1):
    - If word index < DEPTH-1: o_tx_valid<=0, index+1, o_address<=index+1, o_memread<=1 -> READ.
    - Else: o_tx_valid<=0 -> DONE.
- DONE: o_done=1 for exactly one cycle, o_busy<=0, o_address<=0 -> IDLE.
- o_busy=1 from the cycle after the accepted start through the DONE cycle inclusive; low in the cycle after DONE.
- i_tx_ready is ignored when o_tx_valid=0.
- Word index counter is wide enough for DEPTH-1 and stops at DEPTH-1; it never wraps during a dump.
- Per-word overhead: 2 cycles (READ, LATCH) plus DATA_WIDTH/8 transfer cycles. Full dump at defaults with ready held high = 32*(2+4) = 192 cycles from the start edge to the last transfer, then 1 DONE cycle.
- Start asserted in the same cycle as the DONE pulse is ignored; start in the first IDLE cycle after DONE is accepted.

Test Plan:
- Reset: hold i_reset_n=0 with random inputs -> all outputs 0; release, no start -> outputs stay 0.
- Full dump: memory model word k = 32'hA0B0C000+k, i_tx_ready=1 always, start pulse -> 128 bytes, first four A0,B0,C0,00, last four A0,B0,C0,1F; o_done pulses once 193 cycles after start; o_memwrite never 1; o_memread high only in READ/LATCH-entry cycles with o_address=k.
- Backpressure: random i_tx_ready (about 30% high) -> identical byte sequence; o_tx_data never changes while valid=1 and ready=0.
- Start while busy: pulse i_start at byte 10 -> no restart; sequence and done timing unchanged.
- Reset mid-dump: assert i_reset_n=0 at word 5, byte 2 -> outputs 0 asynchronously, no o_done; new start -> dump begins at address 0 with byte A0.
- Back-to-back dumps: start in the cycle after DONE -> second complete 128-byte dump identical to the first.
